// File: rtl/nibbler_bus_pkg.sv
// Shared types and constants for the Nibbler bus arbiter/driver slice.
// The TURN state is entered only when BUS_ARBITER_DRIVER_TURNAROUND_EN is defined.
package nibbler_bus_pkg;

    localparam int NIBBLE_W = 4;
    localparam int HOLD_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } bus_state_e;

    // Hold counter advance: counts up to lim and then sticks there.
    function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] cnt,
                                                   input logic [HOLD_W-1:0] lim);
        logic [HOLD_W-1:0] res;
        if (cnt < lim) begin
            res = cnt + 4'd1;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

endpackage

// File: rtl/bus_arbiter_driver_if.sv
// Source-side handshake bundle of the Nibbler bus arbiter: per-source data and
// requests in, ownership status out. The tri-state bus itself stays a top-level port.
interface bus_arbiter_driver_if #(
    parameter int WIDTH   = nibbler_bus_pkg::NIBBLE_W,
    parameter int NUM_SRC = 4
);
    localparam int IDX_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0][WIDTH-1:0] a;
    logic [NUM_SRC-1:0]            req_n;
    logic [NUM_SRC-1:0]            grant;
    logic [IDX_W-1:0]              owner;
    logic                          busy;

    modport master (
        input  a,
        input  req_n,
        output grant,
        output owner,
        output busy
    );

    modport slave (
        output a,
        output req_n,
        input  grant,
        input  owner,
        input  busy
    );

endinterface

// File: rtl/rr_pick.sv
// Round-robin winner select: first requester strictly after ptr, wrapping, with
// ptr itself considered last so a lone requester can re-win.
module rr_pick #(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   win,
    output logic               found
);

    // Scan farthest-first so the nearest requester after ptr is the last write.
    always_comb begin
        int               idx_v;
        logic [IDX_W-1:0] idx_c;
        win   = '0;
        found = 1'b0;
        idx_v = 0;
        idx_c = '0;
        for (int i = NUM_SRC; i >= 1; i--) begin
            idx_v = int'(ptr) + i;
            idx_v = (idx_v >= NUM_SRC) ? (idx_v - NUM_SRC) : idx_v;
            idx_c = IDX_W'(idx_v);
            if (req[idx_c]) begin
                win   = idx_c;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_driver.sv
// Round-robin, hold-limited owner of the shared Nibbler tri-state bus.
// Define BUS_ARBITER_DRIVER_TURNAROUND_EN to insert one high-Z cycle between owners.
module bus_arbiter_driver
    import nibbler_bus_pkg::*;
#(
    parameter int WIDTH    = NIBBLE_W,
    parameter int NUM_SRC  = 4,
    parameter int HOLD_MAX = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    bus_arbiter_driver_if.master bus,
    output tri   [WIDTH-1:0]     y
);

    localparam int                IDX_W    = $clog2(NUM_SRC);
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);
    localparam logic [IDX_W-1:0]  PTR_RST  = IDX_W'(NUM_SRC - 1);

    bus_state_e          state_r, state_s;
    logic [IDX_W-1:0]    owner_r, owner_s;
    logic [IDX_W-1:0]    ptr_r, ptr_s;
    logic [HOLD_W-1:0]   hold_r, hold_s;
    logic [WIDTH-1:0]    data_r, data_s;
    logic [NUM_SRC-1:0]  grant_r, grant_s;
    logic                busy_r, busy_s;

    logic [NUM_SRC-1:0]  req_s;
    logic [NUM_SRC-1:0]  own_mask_s;
    logic [IDX_W-1:0]    win_s;
    logic                found_s;
    logic                owner_req_s;
    logic                others_s;
    logic                stay_s;

    assign req_s = ~bus.req_n;

    // ptr always holds the last winner, so handoff scans start past the outgoing owner.
    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req   (req_s),
        .ptr   (ptr_r),
        .win   (win_s),
        .found (found_s)
    );

    // Classify current requests relative to the owner.
    always_comb begin
        own_mask_s          = '0;
        own_mask_s[owner_r] = 1'b1;
        owner_req_s         = |(req_s & own_mask_s);
        others_s            = |(req_s & ~own_mask_s);
        stay_s              = owner_req_s && (!others_s || (hold_r < HOLD_LIM));
    end

    // Next-state and datapath updates.
    always_comb begin
        state_s = state_r;
        owner_s = owner_r;
        ptr_s   = ptr_r;
        hold_s  = hold_r;
        data_s  = data_r;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_s = DRIVE;
                    owner_s = win_s;
                    ptr_s   = win_s;
                    data_s  = bus.a[win_s];
                    hold_s  = 4'd1;
                end else begin
                    state_s = IDLE;
                end
            end
            DRIVE: begin
                if (stay_s) begin
                    data_s = bus.a[owner_r];
                    hold_s = hold_inc(hold_r, HOLD_LIM);
                end else if (found_s) begin
`ifdef BUS_ARBITER_DRIVER_TURNAROUND_EN
                    state_s = TURN;
`else
                    state_s = DRIVE;
                    owner_s = win_s;
                    ptr_s   = win_s;
                    data_s  = bus.a[win_s];
                    hold_s  = 4'd1;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
`ifdef BUS_ARBITER_DRIVER_TURNAROUND_EN
            TURN: begin
                if (found_s) begin
                    state_s = DRIVE;
                    owner_s = win_s;
                    ptr_s   = win_s;
                    data_s  = bus.a[win_s];
                    hold_s  = 4'd1;
                end else begin
                    state_s = IDLE;
                end
            end
`endif
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they can be registered.
    always_comb begin
        grant_s = '0;
        if (state_s == DRIVE) begin
            grant_s[owner_s] = 1'b1;
            busy_s           = 1'b1;
        end else begin
            busy_s           = 1'b0;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            owner_r <= '0;
            ptr_r   <= PTR_RST;
            hold_r  <= 4'd0;
            data_r  <= '0;
            grant_r <= '0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            owner_r <= owner_s;
            ptr_r   <= ptr_s;
            hold_r  <= hold_s;
            data_r  <= data_s;
            grant_r <= grant_s;
            busy_r  <= busy_s;
        end
    end

    assign bus.grant = grant_r;
    assign bus.owner = owner_r;
    assign bus.busy  = busy_r;

    // Driven only from registers, so ownership changes cannot glitch the bus.
    assign y = busy_r ? data_r : {WIDTH{1'bz}};

endmodule
